// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Fetch-side producer of the fetch/decode interface. Owns the
//             fetch PC, a req/ack instruction-memory port with variable
//             latency and a small prefetch FIFO. Decode stalls and memory
//             latency are decoupled by the FIFO. Execute redirects flush the
//             FIFO and discard a stale in-flight response.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             imem_req/imem_addr  - fetch request, held stable until ack
//             imem_ack/imem_rdata - memory response (may ack same cycle)
//             stall_F             - decode cannot accept, hold FIFO head
//             redirect_E/target_E - taken branch/jump from execute
//             valid_F, instr_F, PC_F, PCPlus4_F - FIFO head to decode
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall_F,
  input  logic             redirect_E,
  input  logic [WIDTH-1:0] target_E,
  output logic             valid_F,
  output logic [WIDTH-1:0] instr_F,
  output logic [WIDTH-1:0] PC_F,
  output logic [WIDTH-1:0] PCPlus4_F
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_1 = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_1 = c_PTR_W'(1);
  localparam logic [WIDTH-1:0]   c_NOP   = WIDTH'(32'h0000_0013);
  localparam logic [WIDTH-1:0]   c_FOUR  = WIDTH'(4);

  typedef enum logic [0:0] {
    S_FETCH   = 1'b0,
    S_DISCARD = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_req;
  logic [WIDTH-1:0]   r_fetch_pc;
  logic [WIDTH-1:0]   r_stale_addr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [WIDTH-1:0]   r_instr_q [DEPTH];
  logic [WIDTH-1:0]   r_pc_q    [DEPTH];

  logic               w_hs;
  logic               w_push;
  logic               w_pop;
  logic [c_CNT_W-1:0] w_count_next;

  // A handshake in DISCARD belongs to the abandoned request and is dropped.
  // Redirect outranks both push and pop.
  assign w_hs   = r_req & imem_ack;
  assign w_push = w_hs & (r_state == S_FETCH) & ~redirect_E;
  assign w_pop  = valid_F & ~stall_F & ~redirect_E;

  always_comb begin
    w_count_next = r_count;
    if (redirect_E) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + c_CNT_1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_CNT_1;
    end
  end

  assign valid_F   = (r_count != '0);
  assign instr_F   = valid_F ? r_instr_q[r_rd_ptr] : c_NOP;
  assign PC_F      = r_pc_q[r_rd_ptr];
  assign PCPlus4_F = PC_F + c_FOUR;

  // fetch_pc only moves on a push (which ends the request) or a redirect
  // (which moves a pending request onto r_stale_addr), so the address stays
  // constant for as long as imem_req is held.
  assign imem_req  = r_req;
  assign imem_addr = (r_state == S_DISCARD) ? r_stale_addr : r_fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_req        <= 1'b0;
      r_fetch_pc   <= RESET_PC;
      r_stale_addr <= '0;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_q[i] <= '0;
        r_pc_q[i]    <= '0;
      end
    end else begin
      r_count <= w_count_next;

      // A pending request is held until acked; otherwise a new one is
      // issued whenever the FIFO will have room. Because the count cannot
      // grow while a request waits, a push never lands on a full FIFO.
      r_req <= (r_req & ~imem_ack) | (w_count_next < c_FULL);

      case (r_state)
        S_FETCH: begin
          if (redirect_E && r_req && !imem_ack) begin
            r_state      <= S_DISCARD;
            r_stale_addr <= r_fetch_pc;
          end
        end
        S_DISCARD: begin
          if (imem_ack) begin
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase

      if (redirect_E) begin
        r_fetch_pc <= target_E;
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + c_FOUR;
      end

      if (redirect_E) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) begin
          r_instr_q[r_wr_ptr] <= imem_rdata;
          r_pc_q[r_wr_ptr]    <= r_fetch_pc;
          r_wr_ptr            <= r_wr_ptr + c_PTR_1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit: vector table, directed
//             multi-cycle sequences and a randomized run against a
//             queue-based reference model with a variable-latency memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ack, stall_F, redirect_E, valid_F;
  logic [31:0] imem_addr, imem_rdata, target_E, instr_F, PC_F, PCPlus4_F;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall_F(stall_F), .redirect_E(redirect_E), .target_E(target_E),
    .valid_F(valid_F), .instr_F(instr_F), .PC_F(PC_F), .PCPlus4_F(PCPlus4_F)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc, m_stale, p_addr;
  bit          m_disc, m_fresh, m_known;
  bit          p_req, p_ack;

  // memory model
  int fixed_lat = 0;
  int mem_wait  = 0;
  bit mem_busy  = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A4, a[31:16] + 16'h0101};
  endfunction

  function automatic int pick();
    return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample outputs at the negative edge and compare with the model.
  task automatic sample();
    @(negedge clk);
    if (m_known) begin
      if (m_fresh) begin
        chk("rst_req", imem_req, 0);
        chk("rst_pc", PC_F, 0);
        chk("rst_pc4", PCPlus4_F, 4);
      end else if (p_req && !p_ack) begin
        chk("req_hold", imem_req, 1);
        chk("addr_hold", imem_addr, p_addr);
      end else begin
        chk("req_level", imem_req, (q.size() < DEPTH) ? 1 : 0);
      end
      chk("m_valid", valid_F, (q.size() != 0) ? 1 : 0);
      if (q.size() != 0) begin
        chk("m_instr", instr_F, q[0].instr);
        chk("m_pc", PC_F, q[0].pc);
        chk("m_pc4", PCPlus4_F, q[0].pc + 32'd4);
      end else begin
        chk("m_nop", instr_F, NOP);
      end
      if (imem_req) chk("m_addr", imem_addr, m_disc ? m_stale : m_pc);
    end
  endtask

  // Apply inputs for this cycle, answer memory, advance the model, then
  // let the rising edge happen.
  task automatic drive(input bit r, input bit s, input bit d, input logic [31:0] t);
    bit hs, pop;
    rst = r; stall_F = s; redirect_E = d; target_E = t;
    imem_ack = 1'b0; imem_rdata = $urandom;
    if (r) begin
      mem_busy = 0;
    end else if (imem_req) begin
      if (!mem_busy) begin mem_busy = 1; mem_wait = pick(); end
      if (mem_wait == 0) begin
        imem_ack = 1'b1; imem_rdata = mdata(imem_addr); mem_busy = 0;
      end else begin
        mem_wait--;
      end
    end
    p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
    if (r) begin
      q.delete(); m_pc = RESET_PC; m_disc = 0; m_fresh = 1; m_known = 1;
    end else if (m_known) begin
      hs = imem_req && imem_ack;
      m_fresh = 0;
      if (d) begin
        q.delete();
        if (m_disc) begin
          if (hs) m_disc = 0;
        end else if (imem_req && !imem_ack) begin
          m_disc = 1; m_stale = m_pc;
        end
        m_pc = t;
      end else begin
        pop = (q.size() != 0) && !s;
        if (m_disc) begin
          if (hs) m_disc = 0;
        end else if (hs) begin
          q.push_back('{instr: imem_rdata, pc: m_pc});
          m_pc = m_pc + 32'd4;
        end
        if (pop) q.delete(0);
      end
    end
    @(posedge clk);
  endtask

  task automatic tick(input bit r, input bit s, input bit d, input logic [31:0] t);
    sample();
    drive(r, s, d, t);
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit r, s, chk_o, v, req;
    logic [31:0] pc, addr;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit c, bit v, logic [31:0] pc, bit req, logic [31:0] addr);
    vec_t x;
    x.r = r; x.s = s; x.chk_o = c; x.v = v; x.pc = pc; x.req = req; x.addr = addr;
    return x;
  endfunction

  vec_t vt[15];

  initial begin
    bit          found, seen8, got_req, got_valid;
    logic [31:0] first_req, first_valid;
    int          n, vcnt;

    rst = 1'b1; stall_F = 1'b0; redirect_E = 1'b0; target_E = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    m_known = 0; m_fresh = 0; m_disc = 0; p_req = 0; p_ack = 0;
    m_pc = '0; m_stale = '0; p_addr = '0;

    // Zero-latency memory: reset, streaming, then a 6-cycle stall.
    vt[0]  = mk(1, 0, 0, 0, 0,     0, 0);
    vt[1]  = mk(1, 0, 1, 0, 0,     0, 0);
    vt[2]  = mk(0, 0, 1, 0, 0,     0, 0);
    vt[3]  = mk(0, 0, 1, 0, 0,     1, 32'h0);
    vt[4]  = mk(0, 0, 1, 1, 32'h0, 1, 32'h4);
    vt[5]  = mk(0, 0, 1, 1, 32'h4, 1, 32'h8);
    vt[6]  = mk(0, 1, 1, 1, 32'h8, 1, 32'hC);
    for (int i = 7; i < 12; i++) vt[i] = mk(0, 1, 1, 1, 32'h8, 0, 0);
    vt[12] = mk(0, 0, 1, 1, 32'h8,  0, 0);
    vt[13] = mk(0, 0, 1, 1, 32'hC,  1, 32'h10);
    vt[14] = mk(0, 0, 1, 1, 32'h10, 1, 32'h14);

    fixed_lat = 0;
    for (int i = 0; i < 15; i++) begin
      sample();
      if (vt[i].chk_o) begin
        chk($sformatf("tbl%0d_valid", i), valid_F, vt[i].v);
        chk($sformatf("tbl%0d_req", i), imem_req, vt[i].req);
        if (vt[i].v) begin
          chk($sformatf("tbl%0d_pc", i), PC_F, vt[i].pc);
          chk($sformatf("tbl%0d_pc4", i), PCPlus4_F, vt[i].pc + 32'd4);
          chk($sformatf("tbl%0d_instr", i), instr_F, mdata(vt[i].pc));
        end
        if (vt[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, vt[i].addr);
      end
      drive(vt[i].r, vt[i].s, 1'b0, 32'h0);
    end

    // 3-cycle latency: one valid instruction every 4 cycles.
    fixed_lat = 3;
    do_reset();
    for (int i = 0; i < 12; i++) tick(0, 0, 0, 0);
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      sample();
      if (valid_F) vcnt++;
      drive(0, 0, 0, 0);
    end
    chk("a_valid_count", vcnt, 4);

    // Redirect to 0x100 while the request for 0x8 waits 2 more cycles.
    fixed_lat = 2;
    do_reset();
    found = 0; n = 0;
    while (!found && n < 40) begin
      sample();
      if (imem_req && imem_addr == 32'h8) begin
        found = 1;
        drive(0, 0, 1, 32'h100);
      end else begin
        drive(0, 0, 0, 0);
      end
      n++;
    end
    chk("b_found_req8", found, 1);
    sample();
    chk("b_valid_after", valid_F, 0);
    chk("b_disc_req", imem_req, 1);
    chk("b_disc_addr", imem_addr, 32'h8);
    drive(0, 0, 0, 0);
    seen8 = 0; got_req = 0; got_valid = 0;
    first_req = 32'hFFFF_FFFF; first_valid = 32'hFFFF_FFFF;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (valid_F && PC_F == 32'h8) seen8 = 1;
      if (!got_req && imem_req && imem_addr != 32'h8) begin got_req = 1; first_req = imem_addr; end
      if (!got_valid && valid_F) begin got_valid = 1; first_valid = PC_F; end
      drive(0, 0, 0, 0);
    end
    chk("b_no_stale", seen8, 0);
    chk("b_first_req", first_req, 32'h100);
    chk("b_first_valid", first_valid, 32'h100);

    // Redirect in the same cycle as an ack and a pop.
    fixed_lat = 0;
    do_reset();
    found = 0; n = 0;
    while (!found && n < 10) begin
      sample();
      if (valid_F) begin
        found = 1;
        chk("c_req_at_redir", imem_req, 1);
        drive(0, 0, 1, 32'h200);
      end else begin
        drive(0, 0, 0, 0);
      end
      n++;
    end
    chk("c_found_valid", found, 1);
    sample();
    chk("c_valid_after", valid_F, 0);
    chk("c_req_after", imem_req, 1);
    chk("c_addr_after", imem_addr, 32'h200);
    drive(0, 0, 0, 0);
    sample();
    chk("c_valid_tgt", valid_F, 1);
    chk("c_pc_tgt", PC_F, 32'h200);
    drive(0, 0, 0, 0);

    // Reset asserted while a request is waiting.
    fixed_lat = 3;
    do_reset();
    found = 0; n = 0;
    while (!found && n < 10) begin
      sample();
      if (imem_req) found = 1;
      drive(0, 0, 0, 0);
      n++;
    end
    chk("d_found_req", found, 1);
    sample();
    chk("d_waiting", imem_req, 1);
    drive(1, 0, 0, 0);
    sample();
    chk("d_req_rst", imem_req, 0);
    chk("d_valid_rst", valid_F, 0);
    drive(0, 0, 0, 0);
    sample();
    chk("d_req_restart", imem_req, 1);
    chk("d_addr_restart", imem_addr, RESET_PC);
    drive(0, 0, 0, 0);

    // Randomized run against the model.
    fixed_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      bit          r, s, d;
      logic [31:0] t;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      tick(r, s, d, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
